// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// 8 lines of 32-bit data, 2-bit tags, per-line valid bits. Word-addressed RAM
// behind it returns read data combinationally and writes on the rising edge.
// Optional hit/miss statistics counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl_dm (
  input  logic        clock,
  input  logic        i_rst_n,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_we,
  input  logic [4:0]  cpu_req_addr,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rsp_rdata,
  output logic [4:0]  mem_address,
  output logic [31:0] mem_data,
  output logic        mem_rden,
  output logic        mem_wren,
  input  logic [31:0] mem_q
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLookup = 2'd1;
  localparam logic [1:0] StMemRd  = 2'd2;
  localparam logic [1:0] StMemWr  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        req_we_q;
  logic [4:0]  req_addr_q;
  logic [31:0] req_wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic [7:0]  line_valid_q;
  logic [1:0]  line_tag_q  [8];
  logic [31:0] line_data_q [8];

  logic [2:0] idx;
  logic [1:0] tag;
  logic       hit;

  assign idx = req_addr_q[2:0];
  assign tag = req_addr_q[4:3];
  assign hit = line_valid_q[idx] && (line_tag_q[idx] == tag);

  assign cpu_req_ready = (state_q == StIdle);
  assign cpu_rsp_valid = rsp_valid_q;
  assign cpu_rsp_rdata = rsp_rdata_q;

  // Next-state: every accepted request visits LOOKUP, then at most one RAM cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (cpu_req_valid) state_d = StLookup;
      StLookup: begin
        if (req_we_q)  state_d = StMemWr;
        else if (hit)  state_d = StIdle;
        else           state_d = StMemRd;
      end
      StMemRd:  state_d = StIdle;
      StMemWr:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // RAM strobes decode from registered state and the latched request only.
  always_comb begin
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    mem_address = 5'd0;
    mem_data    = 32'd0;
    case (state_q)
      StMemRd: begin
        mem_rden    = 1'b1;
        mem_address = req_addr_q;
      end
      StMemWr: begin
        mem_wren    = 1'b1;
        mem_address = req_addr_q;
        mem_data    = req_wdata_q;
      end
      default: ;
    endcase
  end

  // Control state, request latch, response and valid bits; reset aborts any request.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      req_we_q     <= 1'b0;
      req_addr_q   <= 5'd0;
      req_wdata_q  <= 32'd0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'd0;
      line_valid_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cpu_req_valid) begin
            req_we_q    <= cpu_req_we;
            req_addr_q  <= cpu_req_addr;
            req_wdata_q <= cpu_req_wdata;
          end
        end
        StLookup: begin
          if (!req_we_q && hit) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= line_data_q[idx];
          end
        end
        StMemRd: begin
          rsp_valid_q       <= 1'b1;
          rsp_rdata_q       <= mem_q;
          line_valid_q[idx] <= 1'b1;
        end
        StMemWr: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= 32'd0;
        end
        default: ;
      endcase
    end
  end

  // Line data and tags carry no reset; the cleared valid bits make them don't-care.
  always_ff @(posedge clock) begin
    if (state_q == StMemRd) begin
      line_data_q[idx] <= mem_q;
      line_tag_q[idx]  <= tag;
    end else if (state_q == StMemWr && hit) begin
      line_data_q[idx] <= req_wdata_q;
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Saturating read hit/miss counters, bumped once per read lookup.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_count_q  <= 16'd0;
      miss_count_q <= 16'd0;
    end else if (state_q == StLookup && !req_we_q) begin
      if (hit) begin
        if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
      end else begin
        if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Bench for cache_ctrl_dm: transaction-level cache/RAM model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
// Stats ports are connected and checked when CACHE_CTRL_STATS_EN is defined.
module tb_cache_ctrl_dm;

  logic        clock = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic        cpu_req_we = 1'b0;
  logic [4:0]  cpu_req_addr = 5'd0;
  logic [31:0] cpu_req_wdata = 32'd0;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_rdata;
  logic [4:0]  mem_address;
  logic [31:0] mem_data;
  logic        mem_rden;
  logic        mem_wren;
  logic [31:0] mem_q;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_ctrl_dm dut (
    .clock        (clock),
    .i_rst_n      (i_rst_n),
    .cpu_req_valid(cpu_req_valid),
    .cpu_req_ready(cpu_req_ready),
    .cpu_req_we   (cpu_req_we),
    .cpu_req_addr (cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_rdata(cpu_rsp_rdata),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_rden     (mem_rden),
    .mem_wren     (mem_wren),
    .mem_q        (mem_q)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial forever #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic ram_init = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM attached to the DUT.
  logic [31:0] ram [32];
  assign mem_q = ram[mem_address];
  initial forever begin
    @(posedge clock);
    if (ram_init) for (int i = 0; i < 32; i++) ram[i] = i;
    else if (mem_wren) ram[mem_address] = mem_data;
  end

  // Reference model: cache contents, reference RAM and a per-request timeline.
  logic        m_valid [8];
  logic [1:0]  m_tag   [8];
  logic [31:0] m_data  [8];
  logic [31:0] ref_mem [32];
  logic        busy = 1'b0;
  int          age = 0;
  logic        p_we = 1'b0, p_hit = 1'b0;
  logic [4:0]  p_addr = 5'd0;
  logic [31:0] p_wdata = 32'd0;
  logic        rsp_exp = 1'b0;
  logic [31:0] rsp_data_exp = 32'd0;
  int          m_hits = 0, m_misses = 0;

  initial forever begin
    @(posedge clock or negedge i_rst_n);
    if (ram_init) for (int i = 0; i < 32; i++) ref_mem[i] = i;
    if (!i_rst_n) begin
      busy = 1'b0; age = 0; rsp_exp = 1'b0; m_hits = 0; m_misses = 0;
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    end else begin
      rsp_exp = 1'b0;
      if (busy) begin
        int lat;
        int ix;
        age++;
        lat = (!p_we && p_hit) ? 2 : 3;
        ix = int'(p_addr % 8);
        if (age == lat - 1) begin
          busy = 1'b0;
          rsp_exp = 1'b1;
          if (p_we) begin
            ref_mem[p_addr] = p_wdata;
            if (p_hit) m_data[ix] = p_wdata;
            rsp_data_exp = 32'd0;
          end else if (p_hit) begin
            rsp_data_exp = m_data[ix];
          end else begin
            m_valid[ix] = 1'b1;
            m_tag[ix] = 2'(p_addr / 8);
            m_data[ix] = ref_mem[p_addr];
            rsp_data_exp = ref_mem[p_addr];
          end
        end
      end else if (cpu_req_valid) begin
        int ix;
        busy = 1'b1; age = 0;
        p_we = cpu_req_we; p_addr = cpu_req_addr; p_wdata = cpu_req_wdata;
        ix = int'(p_addr % 8);
        p_hit = m_valid[ix] && (m_tag[ix] == 2'(p_addr / 8));
        if (!p_we) begin
          if (p_hit) m_hits = (m_hits < 65535) ? m_hits + 1 : m_hits;
          else       m_misses = (m_misses < 65535) ? m_misses + 1 : m_misses;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clock);
    if (i_rst_n && !ram_init) begin
      logic rden_exp, wren_exp;
      rden_exp = busy && age == 1 && !p_we && !p_hit;
      wren_exp = busy && age == 1 && p_we;
      chk("ready", 32'(cpu_req_ready), 32'(!busy));
      chk("rsp_valid", 32'(cpu_rsp_valid), 32'(rsp_exp));
      if (rsp_exp) chk("rsp_rdata", cpu_rsp_rdata, rsp_data_exp);
      chk("mem_rden", 32'(mem_rden), 32'(rden_exp));
      chk("mem_wren", 32'(mem_wren), 32'(wren_exp));
      chk("mem_address", 32'(mem_address), (rden_exp || wren_exp) ? 32'(p_addr) : 32'd0);
      if (wren_exp) chk("mem_data", mem_data, p_wdata);
      else if (!rden_exp) chk("mem_data_idle", mem_data, 32'd0);
`ifdef CACHE_CTRL_STATS_EN
      chk("hit_count", 32'(hit_count), 32'(m_hits));
      chk("miss_count", 32'(miss_count), 32'(m_misses));
`endif
    end
  end

  // Issue one request starting at a falling edge; returns at the falling edge
  // where the response is seen, so the next call is back-to-back.
  task automatic req(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                     output int lat, output logic [31:0] data, output int rd, output int wr,
                     output logic [4:0] maddr, output logic [31:0] mdata);
    int w;
    lat = 0; data = 32'd0; rd = 0; wr = 0; maddr = 5'd0; mdata = 32'd0;
    w = 0;
    while (!cpu_req_ready && w < 10) begin
      @(negedge clock);
      w++;
    end
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wdata;
    @(posedge clock);
    #1;
    cpu_req_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      if (mem_rden) begin rd++; maddr = mem_address; end
      if (mem_wren) begin wr++; maddr = mem_address; mdata = mem_data; end
      if (cpu_rsp_valid) begin
        lat = n; data = cpu_rsp_rdata;
        cpu_req_valid = 1'b0;
        break;
      end
      // Junk while busy must be ignored.
      if (n == 1) begin
        cpu_req_valid = 1'($urandom_range(0, 1));
        cpu_req_we = 1'($urandom_range(0, 1));
        cpu_req_addr = 5'($urandom_range(0, 31));
        cpu_req_wdata = $urandom;
      end else begin
        cpu_req_valid = 1'b0;
      end
    end
    if (lat == 0) begin
      errors++; checks++;
      $display("FAIL rsp_timeout: no response within 8 cycles for addr %0d", addr);
    end
  endtask

  task automatic dir(input string name, input logic we, input logic [4:0] addr,
                     input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_data,
                     input int exp_rd, input int exp_wr);
    int lat, rd, wr;
    logic [31:0] data, mdata;
    logic [4:0] maddr;
    req(we, addr, wdata, lat, data, rd, wr, maddr, mdata);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_data"}, data, exp_data);
    chk({name, "_rden_cycles"}, 32'(rd), 32'(exp_rd));
    chk({name, "_wren_cycles"}, 32'(wr), 32'(exp_wr));
    if (exp_rd + exp_wr > 0) chk({name, "_mem_addr"}, 32'(maddr), 32'(addr));
    if (exp_wr > 0) chk({name, "_mem_data"}, mdata, wdata);
  endtask

  task automatic reset_all();
    @(negedge clock);
    i_rst_n = 1'b0; ram_init = 1'b1;
    repeat (2) @(negedge clock);
    ram_init = 1'b0; i_rst_n = 1'b1;
    chk("post_reset_ready", 32'(cpu_req_ready), 32'd1);
    chk("post_reset_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    chk("post_reset_rden", 32'(mem_rden), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rd, wr;
    logic [31:0] data, mdata;
    logic [4:0] maddr;

    reset_all();
    chk("reset_rsp_rdata", cpu_rsp_rdata, 32'd0);

    dir("rd5_miss", 1'b0, 5'd5, 32'd0, 3, 32'h5, 1, 0);
`ifdef CACHE_CTRL_STATS_EN
    chk("lit_miss_count", 32'(miss_count), 32'd1);
    chk("lit_hit_count0", 32'(hit_count), 32'd0);
`endif
    dir("rd5_hit", 1'b0, 5'd5, 32'd0, 2, 32'h5, 0, 0);
`ifdef CACHE_CTRL_STATS_EN
    chk("lit_hit_count1", 32'(hit_count), 32'd1);
`endif
    dir("wr5", 1'b1, 5'd5, 32'hDEADBEEF, 3, 32'd0, 0, 1);
    dir("rd5_after_wr", 1'b0, 5'd5, 32'd0, 2, 32'hDEADBEEF, 0, 0);
    dir("wr9_noalloc", 1'b1, 5'd9, 32'h12345678, 3, 32'd0, 0, 1);
    dir("rd9_miss", 1'b0, 5'd9, 32'd0, 3, 32'h12345678, 1, 0);

    reset_all();
    dir("evict_rd5", 1'b0, 5'd5, 32'd0, 3, 32'h5, 1, 0);
    dir("evict_rd13", 1'b0, 5'd13, 32'd0, 3, 32'hD, 1, 0);
    dir("evict_rd5b", 1'b0, 5'd5, 32'd0, 3, 32'h5, 1, 0);

    // Reset in the middle of a RAM read.
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 5'd7; cpu_req_wdata = 32'd0;
    @(posedge clock);
    #1;
    cpu_req_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("abort_rden_before", 32'(mem_rden), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("abort_rden", 32'(mem_rden), 32'd0);
    chk("abort_wren", 32'(mem_wren), 32'd0);
    chk("abort_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    chk("abort_rsp_rdata", cpu_rsp_rdata, 32'd0);
    chk("abort_ready", 32'(cpu_req_ready), 32'd1);
    chk("abort_mem_address", 32'(mem_address), 32'd0);
    repeat (2) @(negedge clock);
    i_rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      chk("abort_no_rsp", 32'(cpu_rsp_valid), 32'd0);
    end
    dir("rd7_after_abort", 1'b0, 5'd7, 32'd0, 3, 32'h7, 1, 0);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int t = 0; t < 300; t++) begin
      logic we;
      logic [4:0] addr;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clock);
      we = ($urandom_range(0, 9) < 3);
      addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 11));
      req(we, addr, $urandom, lat, data, rd, wr, maddr, mdata);
    end

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
